axis_packet_merger: RTL and testbench
=====================================

# axis_packet_merger

Reassembles fixed-size AXI-Stream packets into one merged packet per channel. It is the receive-side counterpart of the packet splitter. Each channel accepts `packet_count` input packets of exactly `packet_size` beats and forwards them unchanged, except that `tlast` is suppressed on every beat but the last beat of the merged packet. A single control/interrupt interface supervises all channels.

## Interface
Parameters:
- CHANNELS, 1, number of AXI-Stream channels supervised.
- DATA_WIDTH, 16, tdata width per channel.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep.
- KEEP_WIDTH, KEEP_ENABLE ? (DATA_WIDTH+7)/8 : 1, tkeep width.
- ID_ENABLE / DEST_ENABLE / USER_ENABLE, 0, propagate tid / tdest / tuser.
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, enabled ? 8 : 1, sideband widths.
- PCKT_WIDTH, 32, width of packet_size and of the beat counter.
- CNT_WIDTH, 16, width of packet_count and of the packet counter.
- ALLOW_LOCKS, 1, error state is sticky until re-armed.
- RAISE_MISALIGNED, 1, flag an error when input tlast is misplaced or missing.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- operation_start  in  1  one-cycle start strobe.
- packet_size  in  PCKT_WIDTH  beats per input packet; sampled at start.
- packet_count  in  CNT_WIDTH  input packets per merged packet; sampled at start.
- external_error  in  1  abort request.
- operation_busy  out  1  operation in progress.
- operation_complete  out  1  one-cycle completion pulse.
- operation_error  out  1  error flag.
- s_axis_{tdata,tkeep,tvalid,tready,tlast,tid,tdest,tuser}  in/out  CHANNELS×field  slave streams; tready is an output.
- m_axis_{tdata,tkeep,tvalid,tready,tlast,tid,tdest,tuser}  out/in  CHANNELS×field  master streams; tready is an input.

## Operation
- FSM states: IDLE, RUN, DONE, ERROR.
- IDLE
  - On operation_start, latch size and count and clear the per-channel beat counters, packet counters and done bits.
  - If size==0 or count==0, go to ERROR. Otherwise go to RUN.
- RUN
  - Channel ch is active while its done bit is clear.
  - m_tvalid[ch] = s_tvalid[ch] & active[ch]; s_tready[ch] = m_tready[ch] & active[ch].
  - tdata, tkeep, tid, tdest and tuser pass through combinationally.
  - Disabled fields are driven constant: tkeep all-ones; tid, tdest, tuser zero.
  - Each handshake increments the beat counter. At beat==size-1 the beat counter wraps to 0 and the packet counter increments.
  - m_tlast[ch] = (beat==size-1) && (pkt==count-1).
  - The handshake that carries m_tlast sets done[ch].
  - When all done bits are set, go to DONE.
- Alignment check (RAISE_MISALIGNED=1): a handshake with s_tlast=1 at beat≠size-1, or s_tlast=0 at beat==size-1, goes to ERROR. With RAISE_MISALIGNED=0, input tlast is ignored.
- external_error high in RUN goes to ERROR.
- DONE: pulse operation_complete for one cycle, then go to IDLE.
- ERROR
  - All s_tready and m_tvalid are low; operation_error=1.
  - ALLOW_LOCKS=1: stay in ERROR until operation_start, which re-arms exactly as from IDLE, including the zero checks.
  - ALLOW_LOCKS=0: error lasts one cycle, then go to IDLE.
- operation_start outside IDLE/ERROR is ignored.
- Counter arithmetic is unsigned modulo the counter width. A merged packet is size×count beats and must not exceed that product.

## Timing
- Reset values: operation_busy=0, operation_complete=0, operation_error=0, all m_tvalid=0, all s_tready=0, FSM=IDLE, all counters 0.
- Reset is asynchronous; assertion mid-operation clears everything immediately. Any partially transferred packet is abandoned.
- Data path latency: 0 cycles (combinational pass-through, no buffering).
- operation_busy rises the cycle after an accepted start and falls together with operation_complete or operation_error rising.
- operation_complete is high in the cycle after the final handshake of the last channel to finish.
- Misalignment or external_error: ERROR is entered the next cycle.
  - The offending beat itself still transfers.
  - If external_error coincides with the final handshake, error wins and operation_complete is not asserted.
- Zero-size or zero-count start: operation_error rises the cycle after start; busy stays 0.

## Test plan
- CHANNELS=1, size=4, count=3, m_tready=1, input tlast on beats 4/8/12 -> 12 beats out, m_tlast only on beat 12, operation_complete high for one cycle the next cycle, busy low afterwards.
- CHANNELS=2, size=2, count=2, random m_tready per channel, channel 1 delayed 10 cycles -> channel 0 s_tready drops after its 4th beat; complete pulses only after channel 1's 4th beat.
- size=4, count=2, s_tlast on beat 3 -> error next cycle, tready low. With ALLOW_LOCKS=1, error persists until a new start with size=4/count=1 that completes normally.
- Start with packet_size=0 (and separately packet_count=0) -> operation_error the next cycle, no handshakes accepted; with ALLOW_LOCKS=0, error clears after one cycle.
- external_error asserted on beat 5 of 8 -> beat 5 transfers, then ERROR, complete never pulses. A second run with external_error on the final beat also gives error and no complete.
- rst low on beat 3 of 6 -> all outputs 0 asynchronously. After release, a fresh start with size=3/count=2 completes with 6 beats out.

Source files
------------

// File: rtl/axis_packet_merger.sv
// axis_packet_merger: joins packet_count fixed-size AXI-Stream packets per
// channel into a single merged packet. Data passes through with no buffering.
// Input tlast is replaced by a merged tlast on the final beat only. One
// control FSM supervises all channels.
module axis_packet_merger #(
    parameter int CHANNELS         = 1,
    parameter int DATA_WIDTH       = 16,
    parameter bit KEEP_ENABLE      = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH       = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
    parameter bit ID_ENABLE        = 1'b0,
    parameter bit DEST_ENABLE      = 1'b0,
    parameter bit USER_ENABLE      = 1'b0,
    parameter int ID_WIDTH         = ID_ENABLE ? 8 : 1,
    parameter int DEST_WIDTH       = DEST_ENABLE ? 8 : 1,
    parameter int USER_WIDTH       = USER_ENABLE ? 8 : 1,
    parameter int PCKT_WIDTH       = 32,
    parameter int CNT_WIDTH        = 16,
    parameter bit ALLOW_LOCKS      = 1'b1,
    parameter bit RAISE_MISALIGNED = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             operation_start,
    input  logic [PCKT_WIDTH-1:0]            packet_size,
    input  logic [CNT_WIDTH-1:0]             packet_count,
    input  logic                             external_error,
    output logic                             operation_busy,
    output logic                             operation_complete,
    output logic                             operation_error,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [CHANNELS-1:0]              s_axis_tvalid,
    output logic [CHANNELS-1:0]              s_axis_tready,
    input  logic [CHANNELS-1:0]              s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]     s_axis_tid,
    input  logic [CHANNELS*DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [CHANNELS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [CHANNELS-1:0]              m_axis_tvalid,
    input  logic [CHANNELS-1:0]              m_axis_tready,
    output logic [CHANNELS-1:0]              m_axis_tlast,
    output logic [CHANNELS*ID_WIDTH-1:0]     m_axis_tid,
    output logic [CHANNELS*DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [CHANNELS*USER_WIDTH-1:0]   m_axis_tuser
);

    localparam logic [PCKT_WIDTH-1:0] PCKT_ONE = PCKT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

    state_t                 state;
    logic [PCKT_WIDTH-1:0]  size_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [PCKT_WIDTH-1:0]  beat_cnt [CHANNELS];
    logic [CNT_WIDTH-1:0]   pkt_cnt  [CHANNELS];
    logic [CHANNELS-1:0]    done;

    logic [CHANNELS-1:0]    active;
    logic [CHANNELS-1:0]    hs;
    logic [CHANNELS-1:0]    beat_last;
    logic [CHANNELS-1:0]    merged_last;
    logic [CHANNELS-1:0]    misaligned;
    logic [CHANNELS-1:0]    done_next;

    // Sideband inputs that a given configuration may not consume.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser, s_axis_tlast};

    assign m_axis_tdata = s_axis_tdata;

    if (KEEP_ENABLE) begin : g_keep
        assign m_axis_tkeep = s_axis_tkeep;
    end else begin : g_no_keep
        assign m_axis_tkeep = '1;
    end

    if (ID_ENABLE) begin : g_id
        assign m_axis_tid = s_axis_tid;
    end else begin : g_no_id
        assign m_axis_tid = '0;
    end

    if (DEST_ENABLE) begin : g_dest
        assign m_axis_tdest = s_axis_tdest;
    end else begin : g_no_dest
        assign m_axis_tdest = '0;
    end

    if (USER_ENABLE) begin : g_user
        assign m_axis_tuser = s_axis_tuser;
    end else begin : g_no_user
        assign m_axis_tuser = '0;
    end

    // Per-channel gating, handshake detection, merged tlast and alignment check.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            active[ch]        = (state == RUN) && !done[ch];
            beat_last[ch]     = (beat_cnt[ch] == size_r - PCKT_ONE);
            merged_last[ch]   = beat_last[ch] && (pkt_cnt[ch] == count_r - CNT_ONE);
            m_axis_tvalid[ch] = s_axis_tvalid[ch] & active[ch];
            s_axis_tready[ch] = m_axis_tready[ch] & active[ch];
            m_axis_tlast[ch]  = merged_last[ch] & active[ch];
            hs[ch]            = s_axis_tvalid[ch] & m_axis_tready[ch] & active[ch];
            misaligned[ch]    = RAISE_MISALIGNED && hs[ch] && (s_axis_tlast[ch] != beat_last[ch]);
            done_next[ch]     = done[ch] | (hs[ch] & merged_last[ch]);
        end
    end

    // Control FSM with counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            size_r             <= '0;
            count_r            <= '0;
            done               <= '0;
            operation_busy     <= 1'b0;
            operation_complete <= 1'b0;
            operation_error    <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                beat_cnt[ch] <= '0;
                pkt_cnt[ch]  <= '0;
            end
        end else begin
            operation_complete <= 1'b0;
            case (state)
                IDLE, ERROR: begin
                    if (operation_start) begin
                        size_r  <= packet_size;
                        count_r <= packet_count;
                        done    <= '0;
                        for (int ch = 0; ch < CHANNELS; ch++) begin
                            beat_cnt[ch] <= '0;
                            pkt_cnt[ch]  <= '0;
                        end
                        if (packet_size == '0 || packet_count == '0) begin
                            state           <= ERROR;
                            operation_error <= 1'b1;
                            operation_busy  <= 1'b0;
                        end else begin
                            state           <= RUN;
                            operation_error <= 1'b0;
                            operation_busy  <= 1'b1;
                        end
                    end else if (state == ERROR && !ALLOW_LOCKS) begin
                        state           <= IDLE;
                        operation_error <= 1'b0;
                    end
                end
                RUN: begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        if (hs[ch]) begin
                            if (beat_last[ch]) begin
                                beat_cnt[ch] <= '0;
                                pkt_cnt[ch]  <= pkt_cnt[ch] + CNT_ONE;
                            end else begin
                                beat_cnt[ch] <= beat_cnt[ch] + PCKT_ONE;
                            end
                        end
                    end
                    done <= done_next;
                    // An abort or misalignment overrides a coincident completion.
                    if (external_error || (|misaligned)) begin
                        state           <= ERROR;
                        operation_error <= 1'b1;
                        operation_busy  <= 1'b0;
                    end else if (&done_next) begin
                        state              <= DONE;
                        operation_complete <= 1'b1;
                        operation_busy     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_merger.sv
// Bench for axis_packet_merger: a two-channel locking instance driven by a
// vector table, random operations and hand sequences, plus a one-channel
// non-locking instance for the transient error case.
module tb_axis_packet_merger;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit err_latched = 1'b0;

    // Main instance: 2 channels, locking errors
    logic        start;
    logic [31:0] psize;
    logic [15:0] pcount;
    logic        ext;
    logic        busy, cmp, err;
    logic [31:0] s_tdata, m_tdata;
    logic [3:0]  s_tkeep, m_tkeep;
    logic [1:0]  s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [1:0]  s_tid, s_tdest, s_tuser, m_tid, m_tdest, m_tuser;

    axis_packet_merger #(.CHANNELS(2), .ALLOW_LOCKS(1'b1)) dut (
        .clk(clk), .rst(rst_n), .operation_start(start), .packet_size(psize),
        .packet_count(pcount), .external_error(ext), .operation_busy(busy),
        .operation_complete(cmp), .operation_error(err),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser)
    );

    // Second instance: 1 channel, non-locking errors
    logic        nl_start;
    logic [31:0] nl_size;
    logic [15:0] nl_count;
    logic        nl_busy, nl_cmp, nl_err;
    logic [15:0] nl_m_tdata;
    logic [1:0]  nl_m_tkeep;
    logic        nl_s_tready, nl_m_tvalid, nl_m_tlast;
    logic        nl_m_tid, nl_m_tdest, nl_m_tuser;

    axis_packet_merger #(.CHANNELS(1), .ALLOW_LOCKS(1'b0)) dut_nl (
        .clk(clk), .rst(rst_n), .operation_start(nl_start), .packet_size(nl_size),
        .packet_count(nl_count), .external_error(1'b0), .operation_busy(nl_busy),
        .operation_complete(nl_cmp), .operation_error(nl_err),
        .s_axis_tdata(16'h1234), .s_axis_tkeep(2'b11), .s_axis_tvalid(1'b1),
        .s_axis_tready(nl_s_tready), .s_axis_tlast(1'b1), .s_axis_tid(1'b0),
        .s_axis_tdest(1'b0), .s_axis_tuser(1'b0),
        .m_axis_tdata(nl_m_tdata), .m_axis_tkeep(nl_m_tkeep), .m_axis_tvalid(nl_m_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(nl_m_tlast), .m_axis_tid(nl_m_tid),
        .m_axis_tdest(nl_m_tdest), .m_axis_tuser(nl_m_tuser)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_off(input string name);
        chk({name, "_s_tready"}, s_tready, 0);
        chk({name, "_m_tvalid"}, m_tvalid, 0);
        chk({name, "_m_tlast"}, m_tlast, 0);
    endtask

    task automatic idle_in();
        start    = 1'b0;
        ext      = 1'b0;
        s_tvalid = 2'b11;
        m_tready = 2'b11;
        s_tlast  = 2'b00;
        s_tdata  = $urandom;
        s_tkeep  = 4'($urandom);
        s_tid    = 2'($urandom);
        s_tdest  = 2'($urandom);
        s_tuser  = 2'($urandom);
    endtask

    // Runs one operation against a model of the merged stream: each channel
    // must carry exactly size*count beats, merged tlast on the last one only.
    task automatic run_op(input int size, input int count, input int ext_beat,
                          input int bad_beat, input int delay1, input bit rnd,
                          output int dut_beats, output bit got_cmp, output bit got_err);
        int sent [2];
        int n;
        bit err_ev, fin;
        logic [1:0] vld, rdy, lst, exp_rdy, exp_vld, exp_lst;
        n = size * count;
        sent[0] = 0; sent[1] = 0;
        err_ev = 1'b0; fin = 1'b0;
        dut_beats = 0; got_cmp = 1'b0; got_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_in();
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_err", err, err_latched);
            chk("idle_cmp", cmp, 0);
            chk_off("idle");
            @(posedge clk); #1;
        end
        start  = 1'b1;
        psize  = 32'(size);
        pcount = 16'(count);
        @(negedge clk);
        chk_off("start");
        @(posedge clk); #1;
        start = 1'b0;
        if (size == 0 || count == 0) begin
            @(negedge clk);
            chk("zero_err", err, 1);
            chk("zero_busy", busy, 0);
            chk_off("zero");
            got_err = err;
            got_cmp = cmp;
            err_latched = 1'b1;
            @(posedge clk); #1;
            return;
        end
        err_latched = 1'b0;
        for (int cyc = 0; cyc < 400 && !err_ev && !fin; cyc++) begin
            ext = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                vld[ch] = (ch == 1 && cyc < delay1) ? 1'b0 :
                          (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                rdy[ch] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                lst[ch] = (((sent[ch] + 1) % size) == 0);
            end
            if (ext_beat > 0 && sent[0] == ext_beat - 1) begin
                vld[0] = 1'b1; rdy[0] = 1'b1; ext = 1'b1;
            end
            if (bad_beat > 0 && sent[0] == bad_beat - 1) begin
                vld[0] = 1'b1; rdy[0] = 1'b1; lst[0] = ~lst[0];
            end
            s_tvalid = vld; m_tready = rdy; s_tlast = lst;
            s_tdata = $urandom; s_tkeep = 4'($urandom);
            s_tid = 2'($urandom); s_tdest = 2'($urandom); s_tuser = 2'($urandom);
            for (int ch = 0; ch < 2; ch++) begin
                exp_rdy[ch] = (sent[ch] < n) && rdy[ch];
                exp_vld[ch] = (sent[ch] < n) && vld[ch];
                exp_lst[ch] = (sent[ch] == n - 1);
            end
            @(negedge clk);
            chk("s_tready", s_tready, exp_rdy);
            chk("m_tvalid", m_tvalid, exp_vld);
            chk("m_tlast", m_tlast, exp_lst);
            chk("passthru", {m_tdata, m_tkeep}, {s_tdata, s_tkeep});
            chk("side_zero", {m_tid, m_tdest, m_tuser}, 0);
            chk("run_busy", busy, 1);
            chk("run_err", err, 0);
            chk("run_cmp", cmp, 0);
            if (s_tvalid[0] && s_tready[0]) dut_beats++;
            for (int ch = 0; ch < 2; ch++) begin
                if (vld[ch] && exp_rdy[ch]) begin
                    if (lst[ch] != (((sent[ch] + 1) % size) == 0)) err_ev = 1'b1;
                    sent[ch]++;
                end
            end
            if (ext) err_ev = 1'b1;
            fin = (sent[0] >= n) && (sent[1] >= n);
            @(posedge clk); #1;
        end
        idle_in();
        @(negedge clk);
        got_cmp = cmp;
        got_err = err;
        if (err_ev) begin
            chk("err_err", err, 1);
            chk("err_busy", busy, 0);
            chk("err_cmp", cmp, 0);
            chk_off("err");
            err_latched = 1'b1;
        end else if (fin) begin
            chk("done_cmp", cmp, 1);
            chk("done_busy", busy, 0);
            chk("done_err", err, 0);
            chk_off("done");
            @(posedge clk); #1;
            @(negedge clk);
            chk("after_cmp", cmp, 0);
            chk("after_busy", busy, 0);
        end else begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no completion or error, want one within 400 cycles");
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        int size;
        int count;
        int ext_beat;
        int bad_beat;
        int delay1;
        bit rnd;
        bit exp_cmp;
        int exp_beats;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int  beats;
        bit  gc, ge;
        int  sz, ct;

        vecs[0] = '{4, 3, 0, 0, 0,  1'b0, 1'b1, 12};
        vecs[1] = '{2, 2, 0, 0, 10, 1'b1, 1'b1, 4};
        vecs[2] = '{4, 2, 0, 3, 0,  1'b0, 1'b0, 3};
        vecs[3] = '{4, 1, 0, 0, 0,  1'b0, 1'b1, 4};
        vecs[4] = '{0, 3, 0, 0, 0,  1'b0, 1'b0, 0};
        vecs[5] = '{3, 0, 0, 0, 0,  1'b0, 1'b0, 0};
        vecs[6] = '{4, 2, 5, 0, 0,  1'b0, 1'b0, 5};
        vecs[7] = '{4, 2, 8, 0, 0,  1'b0, 1'b0, 8};
        vecs[8] = '{2, 3, 0, 0, 3,  1'b1, 1'b1, 6};

        rst_n = 1'b0;
        nl_start = 1'b0; nl_size = '0; nl_count = '0;
        idle_in();
        psize = '0; pcount = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cmp", cmp, 0);
        chk("rst_err", err, 0);
        chk_off("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].size, vecs[i].count, vecs[i].ext_beat, vecs[i].bad_beat,
                   vecs[i].delay1, vecs[i].rnd, beats, gc, ge);
            chk($sformatf("vec%0d_cmp", i), gc, vecs[i].exp_cmp);
            chk($sformatf("vec%0d_err", i), ge, !vecs[i].exp_cmp);
            chk($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
        end

        // Randomized operations against the model
        for (int i = 0; i < 6; i++) begin
            sz = $urandom_range(1, 5);
            ct = $urandom_range(1, 4);
            run_op(sz, ct, 0, 0, $urandom_range(0, 6), 1'b1, beats, gc, ge);
            chk($sformatf("rnd%0d_cmp", i), gc, 1);
            chk($sformatf("rnd%0d_beats", i), beats, sz * ct);
        end

        // Asynchronous reset in the middle of beat 3 of 6
        idle_in();
        start = 1'b1; psize = 32'd3; pcount = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        s_tvalid = 2'b11; m_tready = 2'b11; s_tlast = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_tlast = 2'b11;
        #1;
        chk("midrst_pre_rdy", s_tready, 2'b11);
        chk("midrst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_cmp", cmp, 0);
        chk_off("midrst");
        @(posedge clk); #1;
        chk_off("midrst_hold");
        rst_n = 1'b1;
        err_latched = 1'b0;
        run_op(3, 2, 0, 0, 0, 1'b0, beats, gc, ge);
        chk("postrst_cmp", gc, 1);
        chk("postrst_beats", beats, 6);

        // Non-locking instance: zero size, then zero count, error lasts one cycle
        for (int i = 0; i < 2; i++) begin
            nl_size  = (i == 0) ? 32'd0 : 32'd4;
            nl_count = (i == 0) ? 16'd5 : 16'd0;
            nl_start = 1'b1;
            @(posedge clk); #1;
            nl_start = 1'b0;
            @(negedge clk);
            chk($sformatf("nl%0d_err", i), nl_err, 1);
            chk($sformatf("nl%0d_busy", i), nl_busy, 0);
            chk($sformatf("nl%0d_rdy", i), {nl_s_tready, nl_m_tvalid}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("nl%0d_err_clear", i), nl_err, 0);
            chk($sformatf("nl%0d_rdy_idle", i), nl_s_tready, 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
